// File: rtl/fpu_addsub_sched.sv
// Two-requester scheduler in front of one shared, fixed-latency FP add/sub unit.
// Define FPU_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module fpu_addsub_sched #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_num1,
  input  logic [31:0] req0_num2,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_num1,
  input  logic [31:0] req1_num2,
  input  logic [1:0]  req1_op,
  output logic [31:0] fu_num1,
  output logic [31:0] fu_num2,
  output logic [1:0]  fu_op,
  input  logic [31:0] fu_result,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // ready never depends on the same port's valid nor on the other port's ready.

  logic        sr_v_q  [LAT];
  logic        sr_id_q [LAT];
  logic [31:0] mem_q   [2][2];
  logic [1:0]  occ_q   [2];
  logic [1:0]  occ_d   [2];
  logic [1:0]  wr_ptr_q;
  logic [1:0]  rd_ptr_q;

  logic [31:0] fu_num1_q, fu_num1_d;
  logic [31:0] fu_num2_q, fu_num2_d;
  logic [1:0]  fu_op_q, fu_op_d;

  logic [3:0]  infl0, infl1;
  logic [1:0]  elig;
  logic        sr_any;
  logic        prio0;
  logic        acc0, acc1, issue;
  logic [1:0]  push, pop;
  logic [1:0]  rsp_ready;

  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // Credit: results in flight plus results buffered may never exceed the 2-entry FIFO.
  always_comb begin
    infl0  = 4'd0;
    infl1  = 4'd0;
    sr_any = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      if (sr_v_q[i]) begin
        sr_any = 1'b1;
        if (sr_id_q[i]) infl1 = infl1 + 4'd1;
        else            infl0 = infl0 + 4'd1;
      end
    end
    elig[0] = ({2'b00, occ_q[0]} + infl0) < 4'd2;
    elig[1] = ({2'b00, occ_q[1]} + infl1) < 4'd2;
  end

`ifdef FPU_SCHED_FIXED_PRIO_EN
  assign prio0 = 1'b1;
`else
  logic last_q;

  // last_q holds the requester granted most recently; the other one wins the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (issue) begin
      last_q <= acc1;
    end
  end

  assign prio0 = last_q;
`endif

  assign req0_ready = !rst && elig[0] && (!(req1_valid && elig[1]) || prio0);
  assign req1_ready = !rst && elig[1] && (!(req0_valid && elig[0]) || !prio0);
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign issue      = acc0 || acc1;

  always_comb begin
    fu_num1_d = fu_num1_q;
    fu_num2_d = fu_num2_q;
    fu_op_d   = fu_op_q;
    if (acc1) begin
      fu_num1_d = req1_num1;
      fu_num2_d = req1_num2;
      fu_op_d   = req1_op;
    end else if (acc0) begin
      fu_num1_d = req0_num1;
      fu_num2_d = req0_num2;
      fu_op_d   = req0_op;
    end
  end

  // The oldest shift-register stage is the operation whose result is on fu_result now.
  always_comb begin
    push[0] = sr_v_q[LAT-1] && !sr_id_q[LAT-1];
    push[1] = sr_v_q[LAT-1] &&  sr_id_q[LAT-1];
    for (int n = 0; n < 2; n++) begin
      pop[n]   = (occ_q[n] != 2'd0) && rsp_ready[n];
      occ_d[n] = occ_q[n] + {1'b0, push[n]} - {1'b0, pop[n]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        sr_v_q[i]  <= 1'b0;
        sr_id_q[i] <= 1'b0;
      end
      fu_num1_q <= 32'd0;
      fu_num2_q <= 32'd0;
      fu_op_q   <= 2'd0;
      wr_ptr_q  <= 2'b00;
      rd_ptr_q  <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        occ_q[n]    <= 2'd0;
        mem_q[n][0] <= 32'd0;
        mem_q[n][1] <= 32'd0;
      end
    end else begin
      sr_v_q[0]  <= issue;
      sr_id_q[0] <= acc1;
      for (int i = 1; i < LAT; i++) begin
        sr_v_q[i]  <= sr_v_q[i-1];
        sr_id_q[i] <= sr_id_q[i-1];
      end
      fu_num1_q <= fu_num1_d;
      fu_num2_q <= fu_num2_d;
      fu_op_q   <= fu_op_d;
      for (int n = 0; n < 2; n++) begin
        occ_q[n] <= occ_d[n];
        if (push[n]) begin
          mem_q[n][wr_ptr_q[n]] <= fu_result;
          wr_ptr_q[n]           <= ~wr_ptr_q[n];
        end
        if (pop[n]) begin
          rd_ptr_q[n] <= ~rd_ptr_q[n];
        end
      end
    end
  end

  assign fu_num1    = fu_num1_q;
  assign fu_num2    = fu_num2_q;
  assign fu_op      = fu_op_q;
  assign rsp0_valid = occ_q[0] != 2'd0;
  assign rsp1_valid = occ_q[1] != 2'd0;
  assign rsp0_data  = mem_q[0][rd_ptr_q[0]];
  assign rsp1_data  = mem_q[1][rd_ptr_q[1]];
  assign busy       = sr_any || (occ_q[0] != 2'd0) || (occ_q[1] != 2'd0);

endmodule

// File: tb/tb_fpu_addsub_sched.sv
// Self-checking bench for fpu_addsub_sched with a behavioural LAT-cycle FP add/sub unit.
module tb_fpu_addsub_sched;
  parameter int LAT = 2;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_num1, req0_num2, req1_num1, req1_num2;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] fu_num1, fu_num2, fu_result, fu_calc;
  logic [1:0]  fu_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic        busy;

  fpu_addsub_sched #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_num1(req0_num1),
    .req0_num2(req0_num2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_num1(req1_num1),
    .req1_num2(req1_num2), .req1_op(req1_op),
    .fu_num1(fu_num1), .fu_num2(fu_num2), .fu_op(fu_op), .fu_result(fu_result),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FP model (exact for small integer operands) ----------------
  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52];
    if (e == 11'd0) return {d[63], 31'd0};
    e = e - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real sp2r(input logic [31:0] s);
    logic [10:0] e;
    if (s[30:23] == 8'd0) return 0.0;
    e = {3'b000, s[30:23]} + 11'd896;
    return $bitstoreal({s[31], e, s[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
    return r2sp(op == 2'd0 ? sp2r(a) + sp2r(b) : sp2r(a) - sp2r(b));
  endfunction

  // Shared unit: result of the launched operands appears LAT edges after launch.
  assign fu_calc = fp_model(fu_num1, fu_num2, fu_op);
  generate
    if (LAT == 1) begin : g_comb
      assign fu_result = fu_calc;
    end else begin : g_pipe
      logic [31:0] pipe [LAT-1];
      always @(posedge clk) begin
        pipe[0] <= fu_calc;
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
      end
      assign fu_result = pipe[LAT-2];
    end
  endgenerate

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          grant_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          acc_cnt0 = 0, acc_cnt1 = 0, rsp_cnt0 = 0, rsp_cnt1 = 0;
  logic [1:0]  s_acc, s_req_ready, s_rsp_valid;
  logic [31:0] s_rsp_data0, s_rsp_data1;
  logic        s_busy;
  int          s_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // One clock: observe at the falling edge (handshakes, pops), then advance past the rising edge.
  task automatic step();
    @(negedge clk);
    s_cyc       = cyc;
    s_acc       = 2'b00;
    s_req_ready = {req1_ready, req0_ready};
    s_rsp_valid = {rsp1_valid, rsp0_valid};
    s_rsp_data0 = rsp0_data;
    s_rsp_data1 = rsp1_data;
    s_busy      = busy;
    if (!rst) begin
      if (req0_valid && req1_valid)
        check("one_accept", 32'(req0_ready && req1_ready), 32'd0);
      if (req0_valid && req0_ready) begin
        exp_q0.push_back(fp_model(req0_num1, req0_num2, req0_op));
        grant_q.push_back(0);
        acc_cnt0++;
        s_acc[0] = 1'b1;
      end
      if (req1_valid && req1_ready) begin
        exp_q1.push_back(fp_model(req1_num1, req1_num2, req1_op));
        grant_q.push_back(1);
        acc_cnt1++;
        s_acc[1] = 1'b1;
      end
      if (rsp0_valid && rsp0_ready) begin
        if (exp_q0.size() == 0) check("rsp0_extra", 32'(rsp0_valid), 32'd0);
        else check("rsp0_data", rsp0_data, exp_q0.pop_front());
        rsp_cnt0++;
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp_q1.size() == 0) check("rsp1_extra", 32'(rsp1_valid), 32'd0);
        else check("rsp1_data", rsp1_data, exp_q1.pop_front());
        rsp_cnt1++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, output int t_acc);
    logic ok;
    ok = 1'b0;
    if (id == 0) begin
      req0_valid = 1'b1; req0_num1 = a; req0_num2 = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_num1 = a; req1_num2 = b; req1_op = op;
    end
    for (int i = 0; i < 100; i++) begin
      step();
      if ((id == 0) ? s_acc[0] : s_acc[1]) begin
        ok = 1'b1;
        break;
      end
    end
    t_acc = cyc;
    check($sformatf("issue%0d_accept", id), 32'(ok), 32'd1);
    if (id == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic flush_sb();
    exp_q0.delete();
    exp_q1.delete();
    grant_q.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    flush_sb();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!s_busy && exp_q0.size() == 0 && exp_q1.size() == 0) break;
    end
    check({tag, "_busy"}, 32'(s_busy), 32'd0);
    check({tag, "_pending"}, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
  endtask

`ifdef FPU_SCHED_FIXED_PRIO_EN
  localparam int TIE_N = 3;
  int tie_exp[4] = '{0, 0, 1, 0};
`else
  localparam int TIE_N = 4;
  int tie_exp[4] = '{0, 1, 0, 1};
`endif

  // ---------------- stimulus ----------------
  initial begin
    int   t, n0, a0, a1, r0, r1;
    logic found;
    rst = 1'b1;
    req0_valid = 1'b0; req0_num1 = '0; req0_num2 = '0; req0_op = '0;
    req1_valid = 1'b0; req1_num1 = '0; req1_num2 = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_rsp0_data", rsp0_data, 32'd0);
    check("rst_rsp1_data", rsp1_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fu_num1", fu_num1, 32'd0);
    check("rst_fu_num2", fu_num2, 32'd0);
    check("rst_fu_op", 32'(fu_op), 32'd0);
    rst = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step();
    check("idle_req0_ready", 32'(s_req_ready[0]), 32'd1);
    check("idle_req1_ready", 32'(s_req_ready[1]), 32'd1);

    // Single op: 1.0 + 2.0 on requester 0.
    issue(0, 32'h3F800000, 32'h40000000, 2'd0, t);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_rsp_valid[0]) begin
        found = 1'b1;
        break;
      end
    end
    check("single_seen", 32'(found), 32'd1);
    check("single_latency", 32'(s_cyc - t), 32'(LAT));
    check("single_data", s_rsp_data0, 32'h40400000);
    drain("single");

    // Tie: both requesters valid continuously from a fresh reset.
    apply_reset();
    req0_valid = 1'b1; req0_num1 = 32'h3F800000; req0_num2 = 32'h3F800000; req0_op = 2'd0;
    req1_valid = 1'b1; req1_num1 = 32'h40000000; req1_num2 = 32'h40000000; req1_op = 2'd0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (grant_q.size() >= TIE_N) break;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("tie_count", 32'(grant_q.size()), 32'(TIE_N));
    for (int i = 0; i < TIE_N; i++)
      check($sformatf("tie_grant%0d", i), 32'(grant_q.size() > i ? grant_q[i] : 99),
            32'(tie_exp[i]));
    drain("tie");

    // Back-pressure on requester 0.
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_num1 = 32'h40400000; req0_num2 = 32'h40800000; req0_op = 2'd0;
    n0 = acc_cnt0;
    repeat (LAT + 10) step();
    check("bp_two_accepted", 32'(acc_cnt0 - n0), 32'd2);
    check("bp_ready_low", 32'(s_req_ready[0]), 32'd0);
    check("bp_busy", 32'(s_busy), 32'd1);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    repeat (LAT + 10) step();
    check("bp_one_more", 32'(acc_cnt0 - n0), 32'd3);
    check("bp_ready_low2", 32'(s_req_ready[0]), 32'd0);
    drain("bp");

    // Ordering on requester 1: 5.0-3.0 then 1.0-1.0.
    rsp1_ready = 1'b0;
    issue(1, 32'h40A00000, 32'h40400000, 2'd1, t);
    issue(1, 32'h3F800000, 32'h3F800000, 2'd2, t);
    repeat (LAT + 2) step();
    check("ord_valid", 32'(s_rsp_valid[1]), 32'd1);
    check("ord_first", s_rsp_data1, 32'h40000000);
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    step();
    check("ord_valid2", 32'(s_rsp_valid[1]), 32'd1);
    check("ord_second", s_rsp_data1, 32'h00000000);
    drain("ord");

    // Reset one cycle after an accept: the result must never appear.
    rsp0_ready = 1'b0;
    issue(0, 32'h40E00000, 32'h3F800000, 2'd0, t);
    step();
    rst = 1'b1;
    flush_sb();
    #1;
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rmid_rsp0_data", rsp0_data, 32'd0);
    check("rmid_fu_num1", fu_num1, 32'd0);
    check("rmid_fu_num2", fu_num2, 32'd0);
    check("rmid_fu_op", 32'(fu_op), 32'd0);
    check("rmid_req0_ready", 32'(req0_ready), 32'd0);
    step();
    rst = 1'b0;
    rsp0_ready = 1'b1;
    repeat (2 * LAT + 4) step();
    check("rmid_after_valid", 32'(s_rsp_valid[0]), 32'd0);
    check("rmid_after_busy", 32'(s_busy), 32'd0);

    // Alternating traffic: saturated phase, then random valid / ready.
    a0 = acc_cnt0; a1 = acc_cnt1; r0 = rsp_cnt0; r1 = rsp_cnt1;
    s_acc = 2'b00;
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid || s_acc[0]) begin
        req0_valid = (c < 120) ? 1'b1 : ($urandom_range(0, 3) != 0);
        req0_num1  = r2sp(real'($urandom_range(0, 15)));
        req0_num2  = r2sp(real'($urandom_range(0, 15)));
        req0_op    = 2'($urandom_range(0, 3));
      end
      if (!req1_valid || s_acc[1]) begin
        req1_valid = (c < 120) ? 1'b1 : ($urandom_range(0, 3) != 0);
        req1_num1  = r2sp(real'($urandom_range(0, 15)));
        req1_num2  = r2sp(real'($urandom_range(0, 15)));
        req1_op    = 2'($urandom_range(0, 3));
      end
      rsp0_ready = (c < 120) ? 1'b1 : ($urandom_range(0, 3) != 0);
      rsp1_ready = (c < 120) ? 1'b1 : ($urandom_range(0, 3) != 0);
      step();
    end
    drain("traffic");
    check("traffic_count0", 32'(rsp_cnt0 - r0), 32'(acc_cnt0 - a0));
    check("traffic_count1", 32'(rsp_cnt1 - r1), 32'(acc_cnt1 - a1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_addsub_sched.md
FPU_ADDSUB_SCHED -- requirements
Module: fpu_addsub_sched

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning the shared add/sub unit's latency in clock edges from operand launch to result sample (legal 1..8).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) operation offered.
REQ-005 SHALL have ports reqN_ready  output  1  requester N operation accepted this cycle.
REQ-006 SHALL have ports reqN_num1, reqN_num2  input  32  IEEE-754 single operands.
REQ-007 SHALL have ports reqN_op  input  2  operation code, 0 = add, nonzero = subtract, passed through unchanged.
REQ-008 SHALL have ports fu_num1, fu_num2  output  32  registered operands to the shared unit.
REQ-009 SHALL have port fu_op  output  2  registered op to the shared unit.
REQ-010 SHALL have port fu_result  input  32  shared unit result.
REQ-011 SHALL have ports rspN_valid  output  1  result available for requester N.
REQ-012 SHALL have ports rspN_ready  input  1  requester N consumes result.
REQ-013 SHALL have ports rspN_data  output  32  head result for requester N.
REQ-014 SHALL have port busy  output  1  high while any operation is in flight or buffered.

Function
REQ-015 SHALL accept at most one request per cycle; handshake = reqN_valid && reqN_ready at a rising edge.
REQ-016 SHALL drive reqN_ready combinationally from eligibility and arbitration, with no dependence on reqN_ready of the other port.
REQ-017 SHALL deem requester N eligible only when (its FIFO occupancy + its in-flight count) < 2.
REQ-018 SHALL, with both eligible and valid, grant the requester not granted last, round-robin; pointer updates only on an accepted issue.
REQ-019 SHALL load fu_num1/fu_num2/fu_op with the accepted operands on the accept edge and hold them otherwise.
REQ-020 SHALL track in-flight operations with a LAT-deep shift register of {valid, requester id}.
REQ-021 SHALL sample fu_result at edge E+LAT for an operation accepted at edge E and write it into that requester's FIFO.
REQ-022 SHALL give each requester a 2-entry FIFO; rspN_valid = occupancy != 0 and rspN_data = head entry.
REQ-023 SHALL pop on rspN_valid && rspN_ready; a push and a pop in the same edge leave occupancy unchanged.
REQ-024 SHALL not bypass: a result written at edge E+LAT is visible on rspN_* only after that edge.
REQ-025 SHALL preserve per-requester issue order in responses; the credit rule SHALL make FIFO overflow impossible.
REQ-026 SHALL allow back-to-back issues every cycle while credit permits, including alternating requesters.
REQ-027 SHALL assert busy when any shift-register valid bit or either FIFO occupancy is nonzero.

Reset
REQ-028 SHALL on rst, asynchronously: clear the shift register, FIFOs and occupancies, set the RR pointer so requester 0 wins the first tie, zero fu_num1/fu_num2/fu_op, and drive reqN_ready=0, rspN_valid=0, rspN_data=0, busy=0.
REQ-029 SHALL discard in-flight operations when rst asserts mid-operation; their results are never delivered.

Configuration
REQ-030 SHALL, with FPU_SCHED_FIXED_PRIO_EN defined, use fixed priority, with requester 0 always winning ties and the RR pointer removed.
REQ-031 SHALL, without FPU_SCHED_FIXED_PRIO_EN, use the round-robin arbitration of REQ-018.

Verification
REQ-032 SHALL cover a single op: req0 1.0+2.0 (0x3F800000, 0x40000000, op 0) at edge E with LAT=2 -> rsp0_valid after E+2, rsp0_data=0x40400000.
REQ-033 SHALL cover a tie: both requesters valid for 4 cycles -> grants 0,1,0,1; with FPU_SCHED_FIXED_PRIO_EN, 0,0 until credit exhausts, then 1.
REQ-034 SHALL cover back-pressure: rsp0_ready=0 and req0 valid continuously -> exactly 2 accepted, req0_ready stays 0 until one pop, then 1 more accepted.
REQ-035 SHALL cover ordering: req1 issues 5.0-3.0 then 1.0-1.0 -> rsp1_data 0x40000000 then 0x00000000, in order.
REQ-036 SHALL cover reset mid-flight: rst pulse 1 cycle after an accept -> no rsp valid afterwards, busy=0, fu_* = 0.
REQ-037 SHALL cover the LAT=1 and LAT=8 builds with continuous alternating traffic -> no lost or duplicated results, busy low after drain.
